// File: rtl/temp_sensor_filter.sv
// Moving-average front end for the thermostat: windowed mean of raw sensor codes, plus stale/open-sensor fault handling.
// Optional output deadband is enabled by defining TEMP_FILTER_DEADBAND_EN.
module temp_sensor_filter #(
  parameter int        SAMPLE_W     = 12,
  parameter int        AVG_LOG2     = 2,
  parameter int signed OFFSET       = 0,
  parameter int        STALE_CYCLES = 1000,
  parameter int        DEADBAND     = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_data,
  output logic signed [31:0]         temp,
  output logic                       temp_valid,
  output logic                       temp_update,
  output logic                       sensor_fault
);

  localparam int N       = 1 << AVG_LOG2;
  localparam int SUM_W   = SAMPLE_W + AVG_LOG2;
  localparam int PTR_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W  = AVG_LOG2 + 1;
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic signed [SAMPLE_W-1:0] OPEN_CODE = {1'b1, {(SAMPLE_W-1){1'b0}}};
`ifdef TEMP_FILTER_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FAULT} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic signed [SAMPLE_W-1:0]  r_win [N];
  logic signed [SUM_W-1:0]     r_sum;
  logic        [PTR_W-1:0]     r_wptr;
  logic        [FILL_W-1:0]    r_fill;
  logic        [STALE_W-1:0]   r_stale;

  logic                        w_open;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_timeout;
  logic signed [SUM_W-1:0]     w_sum_nxt;
  logic signed [31:0]          w_avg;
  logic signed [32:0]          w_diff;
  logic signed [32:0]          w_abs;
  logic                        w_gate;
  logic                        w_load;
  logic                        w_flush;
  logic                        w_enter_fault;
  logic                        w_fill_done;

  assign w_open    = sample_valid && (sample_data == OPEN_CODE);
  assign w_accept  = sample_valid && !w_open;
  assign w_last    = (r_fill == FILL_W'(N - 1));
  assign w_timeout = !w_accept && (r_stale == STALE_W'(STALE_CYCLES - 1));

  // The oldest entry is zero while filling, so the same update works for fill and run.
  assign w_sum_nxt = r_sum + SUM_W'(sample_data) - SUM_W'(r_win[r_wptr]);
  assign w_avg     = 32'(w_sum_nxt >>> AVG_LOG2) + OFFSET;
  assign w_diff    = 33'(w_avg) - 33'(temp);
  assign w_abs     = w_diff[32] ? -w_diff : w_diff;
  assign w_gate    = DB_ON ? (w_abs >= $signed(33'(DEADBAND))) : 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_open || w_timeout)    w_state_nxt = S_FAULT;
        else if (w_accept && w_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_open || w_timeout)    w_state_nxt = S_FAULT;
      end
      S_FAULT: begin
        if (w_accept && w_last)     w_state_nxt = S_RUN;
      end
      default:                      w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    w_enter_fault = 1'b0;
    w_fill_done   = 1'b0;
    w_load        = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_enter_fault = w_open || w_timeout;
        w_load        = w_accept && w_gate;
      end
      S_FILL, S_FAULT: begin
        w_enter_fault = (r_state == S_FILL) && (w_open || w_timeout);
        w_fill_done   = w_accept && w_last;
        w_load        = w_fill_done;
      end
      default: ;
    endcase
    w_flush = w_open || w_enter_fault;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      temp         <= '0;
      temp_valid   <= 1'b0;
      temp_update  <= 1'b0;
      sensor_fault <= 1'b0;
      r_sum        <= '0;
      r_wptr       <= '0;
      r_fill       <= '0;
      r_stale      <= '0;
      for (int i = 0; i < N; i++) r_win[i] <= '0;
    end else begin
      temp_update <= w_load;
      if (w_load) temp <= w_avg;

      if (w_enter_fault)    temp_valid <= 1'b0;
      else if (w_fill_done) temp_valid <= 1'b1;

      if (w_enter_fault)    sensor_fault <= 1'b1;
      else if (w_fill_done) sensor_fault <= 1'b0;

      if (r_state == S_FAULT || w_accept || w_enter_fault) r_stale <= '0;
      else                                                 r_stale <= r_stale + STALE_W'(1);

      if (w_flush) begin
        r_sum  <= '0;
        r_wptr <= '0;
        r_fill <= '0;
        for (int i = 0; i < N; i++) r_win[i] <= '0;
      end else if (w_accept) begin
        r_win[r_wptr] <= sample_data;
        r_sum         <= w_sum_nxt;
        r_wptr        <= (r_wptr == PTR_W'(N - 1)) ? '0 : r_wptr + PTR_W'(1);
        if (r_fill != FILL_W'(N)) r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_temp_sensor_filter.sv
// Bench for temp_sensor_filter: directed scenarios plus random traffic against a queue-based reference model.
module tb_temp_sensor_filter;

  localparam int SAMPLE_W = 12;
  localparam int AVG_LOG2 = 2;
  localparam int N        = 4;
  localparam int STALE    = 16;
  localparam int DB       = 30;
  localparam logic [SAMPLE_W-1:0] OPEN = 12'h800;
`ifdef TEMP_FILTER_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 sample_valid = 1'b0;
  logic [SAMPLE_W-1:0]  sample_data = '0;
  logic signed [31:0]   temp;
  logic                 temp_valid;
  logic                 temp_update;
  logic                 sensor_fault;

  temp_sensor_filter #(
    .SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2), .OFFSET(0),
    .STALE_CYCLES(STALE), .DEADBAND(DB)
  ) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .temp(temp), .temp_valid(temp_valid),
    .temp_update(temp_update), .sensor_fault(sensor_fault)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: list of accepted samples since the last flush, plus mode.
  int q[$];
  int m_mode;   // 0 filling, 1 running, 2 faulted
  int idle;
  int m_temp;
  bit m_valid, m_upd, m_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int win_avg();
    int s;
    s = 0;
    foreach (q[i]) s += q[i];
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0; idle = 0; m_temp = 0;
    m_valid = 0; m_upd = 0; m_fault = 0;
  endtask

  task automatic go_fault();
    q.delete();
    if (m_mode != 2) begin m_fault = 1; m_valid = 0; end
    m_mode = 2; idle = 0;
  endtask

  task automatic model_step(input bit v, input logic [SAMPLE_W-1:0] d);
    int a, diff;
    m_upd = 0;
    if (v && d == OPEN) begin
      go_fault();
    end else if (v) begin
      q.push_back(int'($signed(d)));
      if (q.size() > N) void'(q.pop_front());
      idle = 0;
      a = win_avg();
      if (m_mode == 1) begin
        diff = (a > m_temp) ? a - m_temp : m_temp - a;
        if (!DB_ON || diff >= DB) begin m_temp = a; m_upd = 1; end
      end else if (q.size() == N) begin
        m_mode = 1; m_temp = a; m_upd = 1; m_valid = 1; m_fault = 0;
      end
    end else if (m_mode != 2) begin
      idle++;
      if (idle >= STALE) go_fault();
    end
  endtask

  task automatic cmp_all(input string pfx);
    check_eq({pfx, "_temp"},  temp,         m_temp);
    check_eq({pfx, "_valid"}, temp_valid,   m_valid);
    check_eq({pfx, "_upd"},   temp_update,  m_upd);
    check_eq({pfx, "_fault"}, sensor_fault, m_fault);
  endtask

  task automatic cyc(input bit v, input logic [SAMPLE_W-1:0] d);
    sample_valid = v;
    sample_data  = d;
    @(posedge clock);
    model_step(v, d);
    #1;
    cmp_all("cyc");
  endtask

  task automatic do_reset();
    reset = 1'b0; sample_valid = 1'b0; sample_data = '0;
    @(posedge clock);
    model_reset();
    #1;
    cmp_all("rst");
    reset = 1'b1;
  endtask

  task automatic spaced(input logic [SAMPLE_W-1:0] d);
    cyc(1'b1, d); cyc(1'b0, '0); cyc(1'b0, '0);
  endtask

  int r;
  bit v;
  logic [SAMPLE_W-1:0] d;

  initial begin
    do_reset();

    // Test 1: fill with 100
    for (int i = 0; i < 3; i++) spaced(12'd100);
    check_eq("t1_valid_pre", temp_valid, 0);
    check_eq("t1_temp_pre", temp, 0);
    cyc(1'b1, 12'd100);
    check_eq("t1_temp", temp, 100);
    check_eq("t1_valid", temp_valid, 1);
    check_eq("t1_upd", temp_update, 1);
    cyc(1'b0, '0);
    check_eq("t1_upd_single", temp_update, 0);

    // Test 2: step down to 9
    cyc(1'b1, 12'd9); check_eq("t2_77", temp, DB_ON ? 100 : 77);
    cyc(1'b1, 12'd9); check_eq("t2_54", temp, 54);
    cyc(1'b1, 12'd9); check_eq("t2_31", temp, DB_ON ? 54 : 31);
    cyc(1'b1, 12'd9); check_eq("t2_9", temp, 9);

    // Test 4: stale timeout then recovery
    repeat (STALE) cyc(1'b0, '0);
    check_eq("t4_fault", sensor_fault, 1);
    check_eq("t4_valid", temp_valid, 0);
    check_eq("t4_hold", temp, 9);
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'd20);
    check_eq("t4_fault_pre", sensor_fault, 1);
    cyc(1'b1, 12'd20);
    check_eq("t4_fault_clr", sensor_fault, 0);
    check_eq("t4_valid_up", temp_valid, 1);
    check_eq("t4_temp", temp, 20);

    // Test 3: negative rounding toward minus infinity
    do_reset();
    cyc(1'b1, 12'hFFD); cyc(1'b1, 12'hFFD); cyc(1'b1, 12'hFFD); cyc(1'b1, 12'hFFE);
    check_eq("t3_temp", temp, 32'hFFFF_FFFD);
    check_eq("t3_valid", temp_valid, 1);

    // Test 5: open code in RUN
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd100);
    cyc(1'b1, OPEN);
    check_eq("t5_fault", sensor_fault, 1);
    check_eq("t5_valid", temp_valid, 0);
    check_eq("t5_temp", temp, 100);
    check_eq("t5_upd", temp_update, 0);

    // Test 6: reset mid-fill discards window
    do_reset();
    cyc(1'b1, 12'd50); cyc(1'b1, 12'd50);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'd50);
    check_eq("t6_valid", temp_valid, 0);
    check_eq("t6_temp", temp, 0);
    cyc(1'b1, 12'd50);
    check_eq("t6_temp4", temp, 50);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else if (r < 4) begin
        repeat ($urandom_range(10, 20)) cyc(1'b0, '0);
      end else begin
        v = ($urandom_range(0, 2) != 0);
        d = SAMPLE_W'($urandom);
        r = $urandom_range(0, 39);
        if (r == 0)      d = OPEN;
        else if (r == 1) d = 12'h7FF;
        else if (r == 2) d = 12'h801;
        else if (r < 20) d = SAMPLE_W'($urandom_range(0, 60)) - 12'd30;
        cyc(v, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_sensor_filter.md
Name: temp_sensor_filter

Overview:
- Front-end stage feeding the thermostat controller's signed 32-bit `temp` input.
- Accepts raw signed sensor codes on a valid strobe and produces a moving-average temperature in whole degrees C.
- Flags sensor faults: stale input or open-sensor code.
- Holds the last good reading so the controller never sees garbage.

Parameters:
- SAMPLE_W, 12: width of raw two's-complement sensor code (1 LSB = 1 degC before offset).
- AVG_LOG2, 2: window depth N = 2^AVG_LOG2 samples.
- OFFSET, 0: signed calibration constant, added after averaging.
- STALE_CYCLES, 1000: clock cycles without an accepted sample before a stale fault.
- DEADBAND, 2: minimum output change, in degC; used only with the optional feature.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle.
- sample_data  in  SAMPLE_W  raw signed sensor code.
- temp  out  32  signed filtered temperature in degC; goes to the controller.
- temp_valid  out  1  high while in RUN with a full window.
- temp_update  out  1  one-cycle pulse whenever temp is loaded.
- sensor_fault  out  1  high in FAULT state.

Behaviour:
- Reset (reset==0 at an edge) clears:
  - all outputs to 0;
  - window buffer, running sum and fill count to 0;
  - stale counter to 0;
  - state to FILL.
- Reset mid-operation discards all window contents.
- Open code: sample_data == most-negative value (12'h800 at default). It is never written to the window.
- Accepted sample = sample_valid high and code is not the open code.
- Window: circular buffer of N entries with a write pointer that wraps N-1 -> 0.
  - Running sum is SAMPLE_W+AVG_LOG2 bits, signed.
  - Each accepted sample: sum <= sum + new - oldest; oldest <= new.
- Average = sum arithmetic-shifted right by AVG_LOG2 (floor toward minus infinity), plus OFFSET, sign-extended to 32 bits.
- Latency: an accepted sample at edge k updates temp and pulses temp_update at edge k+1 (registered output).
- States:
  - FILL:
    - Accepted samples fill the window; temp and temp_valid are unchanged.
    - On the Nth accepted sample: go to RUN, load temp, temp_valid=1, pulse temp_update, clear sensor_fault.
  - RUN: every accepted sample loads temp and pulses temp_update.
  - FAULT:
    - Entered from FILL or RUN on a stale timeout, or on an open-code sample (sample_valid high).
    - On entry: sensor_fault=1, temp_valid=0, temp holds its last value, window and fill count flushed.
    - Next accepted sample counts as sample 1 of a new fill.
    - sensor_fault stays 1 until the Nth accepted sample; then go to RUN as above.
- Stale counter:
  - Increments every cycle in FILL and RUN; cleared by every accepted sample; frozen at 0 in FAULT.
  - Reaching STALE_CYCLES (counted from reset release or from the last accepted sample) enters FAULT.
  - An accepted sample in the same cycle as the timeout wins: no fault.
- No arithmetic overflow: sum width covers N full-scale samples. OFFSET addition is done in 32 bits.

Optional Feature:
- Macro: TEMP_FILTER_DEADBAND_EN.
- Defined (RUN only):
  - A new average loads temp and pulses temp_update only if |average - temp| >= DEADBAND.
  - Otherwise temp is held and there is no pulse.
  - The FILL->RUN transition always loads temp.
  - This suppresses heater/cooler chatter near thresholds.
- Undefined: every accepted sample in RUN loads temp and pulses temp_update, even if the value is unchanged.

Test Plan:
Defaults, except STALE_CYCLES=16 and the feature undefined.
1. Release reset; send four samples of 100, one every 3 cycles. Required: temp_valid=0 and temp=0 through the 3rd sample; the edge after the 4th gives temp=100, temp_valid=1 and a single temp_update pulse.
2. From test 1, send four samples of 9. Required: temp = 77, 54, 31, 9 in sequence, one temp_update pulse per sample.
3. After reset, send four samples of -3, -3, -3, -2 (12'hFFD/FFD/FFD/FFE). Required: sum=-11, temp=-3 (32'hFFFFFFFD), temp_valid=1.
4. In RUN with temp=9, send no samples for 16 cycles. Required: sensor_fault=1, temp_valid=0, temp stays 9. Then send four samples of 20. Required: sensor_fault clears and temp_valid rises on the edge after the 4th sample; temp=20.
5. In RUN with temp=100, send one sample of 12'h800. Required: next edge gives sensor_fault=1, temp_valid=0, temp=100, no temp_update pulse.
6. Send two samples of 50, then hold reset low for one cycle, then send three samples of 50. Required: temp_valid stays 0 and temp=0. The fourth post-reset sample gives temp=50.
7. Repeat test 2 with TEMP_FILTER_DEADBAND_EN defined, DEADBAND=30. Required: temp goes 100 -> 54 (the average of 77 is suppressed), then 54 stays (31 is 23 below 54, suppressed), then 9 is loaded; 2 temp_update pulses total.
